// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to the L1
// instruction cache (one outstanding at most), buffers returned words in a
// small prefetch queue and hands them to decode over a valid/ready handshake.
// Redirects flush the queue and discard any response still in flight.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  output logic              cache_req,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cache_data,
  input  logic              cache_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FETCH: nothing outstanding; WAIT: response pending and wanted;
  // DROP: response pending but stale after a redirect.
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, inflight_pc;
  logic [ADDR_W-1:0] q_pc   [QDEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              outstanding, has_room, issue, push, pop;

  // A slot is reserved for the outstanding response; a pop in the same
  // cycle does not free space for a new request.
  assign outstanding = (state != S_FETCH);
  assign has_room    = (count + CNT_W'(outstanding)) < CNT_W'(QDEPTH);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= S_FETCH;
    else if (clk_en) state <= state_nxt;
  end

  // Next-state logic; a redirect decides whether the pending response is
  // already here (drop it now) or still to come (remember to drop it).
  always_comb begin
    // NOTE: defaulting every always_comb output first guarantees no latch is
    // inferred on paths that do not assign it.
    state_nxt = state;
    case (state)
      S_FETCH: if (issue) state_nxt = S_WAIT;
      S_WAIT: begin
        if (redirect_valid)   state_nxt = cache_ready ? S_FETCH : S_DROP;
        else if (cache_ready) state_nxt = issue ? S_WAIT : S_FETCH;
      end
      S_DROP:  if (cache_ready) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Control outputs: request issue, queue push and queue pop.
  always_comb begin
    issue = 1'b0;
    if (rst_n && !redirect_valid && has_room)
      issue = (state == S_FETCH) || (state == S_WAIT && cache_ready);
    push = (state == S_WAIT) && cache_ready && !redirect_valid;
    pop  = instr_valid && instr_ready && !redirect_valid;
  end

  // Program counter and the address of the request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
    end else if (clk_en) begin
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(1);
      end
    end
  end

  // Queue pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Queue storage.
  // NOTE: the storage array is not reset; occupancy is tracked by count and
  // the head is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (clk_en && push) begin
      q_pc[wr_ptr]   <= inflight_pc;
      q_data[wr_ptr] <= cache_data;
    end
  end

  assign cache_req   = issue;
  assign cache_addr  = pc;
  assign instr_valid = (count != '0);
  assign instr_data  = instr_valid ? q_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr]   : '0;

  // The issue condition must never let a response arrive into a full queue.
  push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(clk_en && push && count == CNT_W'(QDEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural cache with random
// latency plus a queue-based reference model of the fetch stream.
module tb_fetch_unit;
  localparam int          ADDR_W   = 16;
  localparam int          DATA_W   = 32;
  localparam int          QDEPTH   = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic              clk = 1'b0;
  logic              rst_n, clk_en;
  logic              cache_req, cache_ready;
  logic [ADDR_W-1:0] cache_addr, redirect_pc, instr_pc;
  logic [DATA_W-1:0] cache_data, instr_data;
  logic              redirect_valid, instr_valid, instr_ready;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .cache_req(cache_req), .cache_addr(cache_addr),
    .cache_data(cache_data), .cache_ready(cache_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected instruction stream as a queue of {pc, word}.
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      mq[$];
  logic [15:0] m_pc;
  bit          m_pend, m_drop;
  logic [15:0] m_pend_addr;

  // Cache environment: one request at a time, random extra latency.
  bit          c_busy, c_hold, c_late;
  logic [15:0] c_addr;
  int          c_lat, lat_max;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'hA000_0000 + {16'h0000, a};
  endfunction

  // One clock cycle: drive inputs at negedge, compare, then advance models.
  task automatic step(input bit rv, input logic [15:0] ra, input bit rdy, input bit en);
    bit          exp_issue, popd, s_req;
    logic [15:0] s_addr;
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = ra;
    instr_ready    = rdy;
    clk_en         = en;
    if (c_late) begin
      cache_ready = 1'b1;
      cache_data  = 32'hDEAD_BEEF;
    end else if (c_busy && !c_hold && c_lat == 0) begin
      cache_ready = 1'b1;
      cache_data  = mem_word(c_addr);
    end else begin
      cache_ready = 1'b0;
      cache_data  = $urandom;
    end
    #1;
    exp_issue = !rv && (mq.size() + int'(m_pend) < QDEPTH) &&
                (!m_pend || (!m_drop && cache_ready));
    check("cache_req", cache_req, exp_issue);
    check("cache_addr", cache_addr, m_pc);
    check("instr_valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("instr_pc", instr_pc, mq[0].pc);
      check("instr_data", instr_data, mq[0].data);
    end
    s_req  = cache_req;
    s_addr = cache_addr;
    @(posedge clk);
    if (en) begin
      if (cache_ready) begin
        c_busy = 1'b0;
        c_late = 1'b0;
      end else if (c_busy && !c_hold && c_lat > 0) begin
        c_lat--;
      end
      if (s_req) begin
        c_busy = 1'b1;
        c_addr = s_addr;
        c_lat  = int'($urandom_range(lat_max, 0));
      end
      popd = !rv && mq.size() != 0 && rdy;
      if (rv) begin
        mq.delete();
        m_pc = ra;
        if (m_pend) begin
          if (cache_ready) begin
            m_pend = 1'b0;
            m_drop = 1'b0;
          end else begin
            m_drop = 1'b1;
          end
        end
      end else begin
        if (popd) void'(mq.pop_front());
        if (m_pend && cache_ready) begin
          if (!m_drop) mq.push_back({m_pend_addr, mem_word(m_pend_addr)});
          m_pend = 1'b0;
          m_drop = 1'b0;
        end
        if (exp_issue) begin
          m_pend      = 1'b1;
          m_drop      = 1'b0;
          m_pend_addr = m_pc;
          m_pc        = m_pc + 16'd1;
        end
      end
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_instr_valid", instr_valid, 0);
    check("rst_cache_req", cache_req, 0);
    check("rst_instr_data", instr_data, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_cache_addr", cache_addr, RESET_PC);
    c_late = c_busy;
    c_busy = 1'b0;
    c_hold = 1'b0;
    mq.delete();
    m_pc   = RESET_PC;
    m_pend = 1'b0;
    m_drop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; cache_ready = 1'b0; cache_data = '0;
    c_busy = 0; c_hold = 0; c_late = 0; c_addr = '0; c_lat = 0; lat_max = 0;
    m_pc = RESET_PC; m_pend = 0; m_drop = 0; m_pend_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_instr_valid", instr_valid, 0);
    check("init_cache_req", cache_req, 0);
    check("init_instr_data", instr_data, 0);
    check("init_cache_addr", cache_addr, RESET_PC);
    rst_n = 1'b1;

    // Streaming at 1-cycle latency, decode always ready.
    repeat (12) step(0, '0, 1, 1);

    // Decode stalled: queue fills to QDEPTH and requests stop, then drain.
    repeat (8) step(0, '0, 0, 1);
    check("full_no_req", cache_req, 0);
    check("full_head_pc", instr_pc, mq.size() != 0 ? mq[0].pc : 16'hxxxx);
    repeat (10) step(0, '0, 1, 1);

    // Redirect while a miss is pending; the late response must be dropped.
    c_hold = 1'b1;
    repeat (2) step(0, '0, 1, 1);
    step(1, 16'h0100, 1, 1);
    step(0, '0, 1, 1);
    c_hold = 1'b0;
    step(0, '0, 1, 1);
    check("drop_empty", instr_valid, 0);
    repeat (6) step(0, '0, 1, 1);

    // Redirect coinciding with a cache response and a decode pop.
    step(1, 16'h0020, 1, 1);
    repeat (6) step(0, '0, 1, 1);

    // PC wrap at 0xFFFF, with a 3-cycle global stall mid-stream.
    step(1, 16'hFFFD, 1, 1);
    repeat (4) step(0, '0, 1, 1);
    repeat (3) step(0, '0, 1, 0);
    repeat (6) step(0, '0, 1, 1);

    // Reset with a request outstanding and two words queued.
    step(1, 16'h0300, 0, 1);
    repeat (3) step(0, '0, 0, 1);
    async_reset();
    repeat (8) step(0, '0, 1, 1);

    // Randomized traffic: misses, back-pressure, stalls and redirects.
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      bit          rv, rdy, en;
      logic [15:0] ra;
      rv  = ($urandom_range(99, 0) < 4);
      rdy = ($urandom_range(99, 0) < 75);
      en  = ($urandom_range(99, 0) < 90);
      ra  = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
      step(rv, ra, rdy, en);
    end

    // Mid-stream reset under random latency, then recovery.
    async_reset();
    repeat (40) step(0, '0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
